pkt_framer: RTL and testbench
=============================

Name: pkt_framer

Overview:
Upstream frame assembler for the packet parser. It takes a byte stream, packs each 40-byte payload MSB-first into the 320-bit word the CRC-32 engine consumes, and latches the trailing 4-byte FCS. It hands the word to the CRC engine and waits for its done pulse. It then compares the computed CRC against the received FCS and presents payload plus verdict downstream toward the FIFO.

Parameters:
PAYLOAD_BYTES, 40, payload bytes per frame; crc_data width = 8*PAYLOAD_BYTES.
FCS_BYTES, 4, FCS bytes per frame; fixed at 4 for CRC-32.
TIMEOUT_CYCLES, 64, max cycles in CRC_WAIT before abandoning the frame; must exceed the CRC engine latency (~42).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_sof  in  1  marks first byte of a frame
in_ready  out  1  framer accepts a byte this cycle
crc_valid  out  1  one-cycle start pulse to CRC engine
crc_data  out  8*PAYLOAD_BYTES  packed payload; byte 0 in [319:312]
crc_done  in  1  CRC engine done pulse
crc_value  in  32  CRC engine result, valid with crc_done
out_valid  out  1  frame available
out_ready  in  1  downstream accepts frame
out_payload  out  8*PAYLOAD_BYTES  packed payload
out_crc_ok  out  1  crc_value == received FCS
out_timeout  out  1  CRC engine did not answer in time

Behaviour:
- Accept = in_valid & in_ready. in_ready = 1 in IDLE, COLLECT and FCS; 0 in CRC_REQ, CRC_WAIT and OUTPUT.
- Reset (async, rst=1): state IDLE; in_ready=1; crc_valid=0; crc_data=0; out_valid=0; out_payload=0; out_crc_ok=0; out_timeout=0; byte counter=0; FCS register=0. Reset mid-frame discards all partial data.
- IDLE:
  - Accepted byte with in_sof=1 is stored as payload byte 0; go to COLLECT with count=1.
  - Accepted byte with in_sof=0 is dropped.
- COLLECT:
  - Byte k is stored at crc_data[8*(PAYLOAD_BYTES-1-k) +: 8].
  - After byte PAYLOAD_BYTES-1 is accepted, go to FCS with count=0.
  - A byte with in_sof=1 restarts the frame: that byte becomes byte 0, count=1, and the old data is abandoned.
- FCS:
  - FCS byte j is stored at fcs[8*j +: 8] (little-endian, matching LSB-first CRC-32 transmission).
  - in_sof=1 here also restarts in COLLECT as above.
  - After byte FCS_BYTES-1, go to CRC_REQ.
- CRC_REQ: crc_valid=1 for exactly one cycle; go to CRC_WAIT and clear the timeout counter.
- crc_data is held stable from CRC_REQ until leaving CRC_WAIT, because the engine reads it over many cycles.
- CRC_WAIT:
  - On crc_done=1: out_crc_ok = (crc_value == fcs); out_timeout=0; go to OUTPUT.
  - When the timer reaches TIMEOUT_CYCLES-1 without crc_done: out_crc_ok=0; out_timeout=1; go to OUTPUT.
  - crc_done in the same cycle as timer expiry: crc_done wins.
- OUTPUT:
  - out_valid=1; out_payload, out_crc_ok and out_timeout are stable while out_valid & !out_ready.
  - On out_ready: out_valid=0 next cycle; go to IDLE.
- Stray crc_done outside CRC_WAIT is ignored.
- Latency: last FCS byte accepted at edge N → crc_valid high in cycle N+1. crc_done at edge M → out_valid high in cycle M+1.
- No frame overlap: input is back-pressured until the frame is handed off.

Optional Feature:
PKT_FRAMER_STATS_EN.
- Defined: adds outputs stat_ok, stat_bad, stat_drop (each 16-bit, saturating at 0xFFFF, cleared by rst).
  - stat_ok increments on an OUTPUT handoff with out_crc_ok=1.
  - stat_bad increments on a handoff with out_crc_ok=0.
  - stat_drop increments for each byte dropped in IDLE and each in_sof restart in COLLECT/FCS.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Good frame (CRC stub): payload bytes 0x00..0x27, FCS bytes EF BE AD DE; stub returns crc_done with crc_value=0xDEADBEEF 42 cycles after crc_valid → crc_data[319:312]=0x00, crc_data[7:0]=0x27; one crc_valid pulse; out_valid with out_crc_ok=1, out_timeout=0.
- Bad FCS: same payload, FCS 00 00 00 00, stub returns 0xDEADBEEF → out_crc_ok=0; with PKT_FRAMER_STATS_EN, stat_bad=1.
- Real crc instance: random 40-byte payload plus software CRC-32 FCS → out_crc_ok=1; crc_data constant for the whole CRC_WAIT.
- SOF restart: 10 bytes, then in_sof=1 byte 0xAA, then 39 bytes + FCS → out_payload[319:312]=0xAA; stat_drop=1; exactly one output frame.
- Timeout: stub never asserts crc_done → out_valid exactly 64 cycles after CRC_WAIT entry; out_timeout=1; out_crc_ok=0. Also hold out_ready=0 for 5 cycles → outputs stable, in_ready=0.
- Reset mid-frame: assert rst after 20 bytes → all outputs return to reset values immediately; next full good frame is processed correctly.

Source files
------------

// File: rtl/pkt_framer.sv
// Frame assembler: packs a 40-byte payload MSB-first for the CRC-32 engine, latches the FCS,
// and presents payload plus CRC verdict downstream. Define PKT_FRAMER_STATS_EN for ok/bad/drop counters.
module pkt_framer #(
  parameter int PAYLOAD_BYTES  = 40,
  parameter int FCS_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  input  logic [7:0]                 in_data_i,
  input  logic                       in_sof_i,
  output logic                       in_ready_o,
  output logic                       crc_valid_o,
  output logic [8*PAYLOAD_BYTES-1:0] crc_data_o,
  input  logic                       crc_done_i,
  input  logic [31:0]                crc_value_i,
`ifdef PKT_FRAMER_STATS_EN
  output logic [15:0]                stat_ok_o,
  output logic [15:0]                stat_bad_o,
  output logic [15:0]                stat_drop_o,
`endif
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [8*PAYLOAD_BYTES-1:0] out_payload_o,
  output logic                       out_crc_ok_o,
  output logic                       out_timeout_o
);

  localparam int PW = 8 * PAYLOAD_BYTES;
  localparam int FW = 8 * FCS_BYTES;
  localparam int CW = $clog2(PAYLOAD_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_FCS, S_CRC_REQ, S_CRC_WAIT, S_OUTPUT
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [TW-1:0]  timer_q;
  logic [FW-1:0]  fcs_q;
  logic [PW-1:0]  payload_q;
  logic [PW-1:0]  out_payload_q;
  logic           in_ready_q;
  logic           crc_valid_q;
  logic           out_valid_q;
  logic           out_crc_ok_q;
  logic           out_timeout_q;
  logic           accept_d;

  assign accept_d = in_valid_i & in_ready_q;

`ifdef PKT_FRAMER_STATS_EN
  logic [15:0] stat_ok_q, stat_bad_q, stat_drop_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Payload shifts in MSB-first so byte 0 lands on top once all bytes are in;
  // FCS shifts in from the top so byte 0 ends up in the low byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      timer_q       <= '0;
      fcs_q         <= '0;
      payload_q     <= '0;
      out_payload_q <= '0;
      in_ready_q    <= 1'b1;
      crc_valid_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_crc_ok_q  <= 1'b0;
      out_timeout_q <= 1'b0;
`ifdef PKT_FRAMER_STATS_EN
      stat_ok_q     <= '0;
      stat_bad_q    <= '0;
      stat_drop_q   <= '0;
`endif
    end else begin
      crc_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d && in_sof_i) begin
            payload_q <= {payload_q[PW-9:0], in_data_i};
            cnt_q     <= CW'(1);
            state_q   <= S_COLLECT;
          end
        end
        S_COLLECT, S_FCS: begin
          if (accept_d) begin
            if (in_sof_i) begin
              payload_q <= {payload_q[PW-9:0], in_data_i};
              cnt_q     <= CW'(1);
              state_q   <= S_COLLECT;
            end else if (state_q == S_COLLECT) begin
              payload_q <= {payload_q[PW-9:0], in_data_i};
              if (cnt_q == CW'(PAYLOAD_BYTES - 1)) begin
                cnt_q   <= '0;
                state_q <= S_FCS;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end else begin
              fcs_q <= {in_data_i, fcs_q[FW-1:8]};
              if (cnt_q == CW'(FCS_BYTES - 1)) begin
                cnt_q       <= '0;
                in_ready_q  <= 1'b0;
                crc_valid_q <= 1'b1;
                state_q     <= S_CRC_REQ;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
        end
        S_CRC_REQ: begin
          timer_q <= TW'(TIMEOUT_CYCLES - 1);
          state_q <= S_CRC_WAIT;
        end
        S_CRC_WAIT: begin
          if (crc_done_i) begin
            out_crc_ok_q  <= (crc_value_i == fcs_q);
            out_timeout_q <= 1'b0;
            out_payload_q <= payload_q;
            out_valid_q   <= 1'b1;
            state_q       <= S_OUTPUT;
          end else if (timer_q == '0) begin
            out_crc_ok_q  <= 1'b0;
            out_timeout_q <= 1'b1;
            out_payload_q <= payload_q;
            out_valid_q   <= 1'b1;
            state_q       <= S_OUTPUT;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef PKT_FRAMER_STATS_EN
      if (accept_d && ((state_q == S_IDLE && !in_sof_i) ||
                       ((state_q == S_COLLECT || state_q == S_FCS) && in_sof_i)))
        stat_drop_q <= sat_inc(stat_drop_q);
      if (state_q == S_OUTPUT && out_ready_i) begin
        if (out_crc_ok_q) stat_ok_q  <= sat_inc(stat_ok_q);
        else              stat_bad_q <= sat_inc(stat_bad_q);
      end
`endif
    end
  end

  assign in_ready_o    = in_ready_q;
  assign crc_valid_o   = crc_valid_q;
  assign crc_data_o    = payload_q;
  assign out_valid_o   = out_valid_q;
  assign out_payload_o = out_payload_q;
  assign out_crc_ok_o  = out_crc_ok_q;
  assign out_timeout_o = out_timeout_q;
`ifdef PKT_FRAMER_STATS_EN
  assign stat_ok_o     = stat_ok_q;
  assign stat_bad_o    = stat_bad_q;
  assign stat_drop_o   = stat_drop_q;
`endif

endmodule

// File: tb/tb_pkt_framer.sv
// Bench for pkt_framer: table of frame vectors plus hand sequences, CRC engine stub,
// scoreboard of expected frames. Stat checks build only with PKT_FRAMER_STATS_EN.
module tb_pkt_framer;
  localparam int PB = 40;
  localparam int W  = 8 * PB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_sof = 1'b0, in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         crc_valid, crc_done = 1'b0;
  logic [W-1:0] crc_data, out_payload;
  logic [31:0]  crc_value = 32'h0;
  logic         out_valid, out_ready = 1'b0, out_crc_ok, out_timeout;
`ifdef PKT_FRAMER_STATS_EN
  logic [15:0]  stat_ok, stat_bad, stat_drop;
`endif

  pkt_framer dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_sof_i(in_sof), .in_ready_o(in_ready),
    .crc_valid_o(crc_valid), .crc_data_o(crc_data),
    .crc_done_i(crc_done), .crc_value_i(crc_value),
`ifdef PKT_FRAMER_STATS_EN
    .stat_ok_o(stat_ok), .stat_bad_o(stat_bad), .stat_drop_o(stat_drop),
`endif
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_payload_o(out_payload),
    .out_crc_ok_o(out_crc_ok), .out_timeout_o(out_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int e_ok = 0, e_bad = 0, e_drop = 0;

  typedef struct {
    bit          rnd;
    logic [31:0] fcs;
    bit          fcs_sw;
    int          delay;
    bit          real_crc;
    logic [31:0] scrc;
    bit          eok;
    bit          eto;
    int          edelta;
  } vec_t;

  typedef struct {
    logic [W-1:0] payload;
    bit           ok;
    bit           to;
    int           delta;
  } sb_t;

  vec_t vt[7];
  sb_t  sb[$];

  // CRC engine stub state
  int           stub_delay = 42;
  bit           stub_real  = 1'b0;
  logic [31:0]  stub_crc   = 32'h0;
  int           crc_pulses = 0;
  int           cv_cyc     = 0;
  logic [W-1:0] cv_data    = '0;
  int           unstable   = 0;

  function automatic logic [31:0] crc32(input logic [W-1:0] d);
    logic [31:0] c;
    logic [W-1:0] s;
    c = 32'hFFFFFFFF;
    s = d;
    for (int i = 0; i < PB; i++) begin
      c = c ^ {24'h0, s[W-1:W-8]};
      s = s << 8;
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [W-1:0] gen(input bit rnd);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < PB; i++) p = {p[W-9:0], rnd ? 8'($urandom_range(0, 255)) : 8'(i)};
    return p;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (crc_valid) begin
      crc_pulses++;
      cv_cyc  = cyc;
      cv_data = crc_data;
      if (stub_delay > 0) begin
        repeat (stub_delay) @(negedge clk);
        crc_value = stub_real ? crc32(cv_data) : stub_crc;
        crc_done  = 1'b1;
        @(negedge clk);
        crc_done  = 1'b0;
        crc_value = 32'h0;
      end
    end
  end

  // crc_data must not move between the start pulse and the frame appearing downstream
  initial begin
    logic [W-1:0] snap;
    bit watching;
    watching = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (crc_valid) begin
        snap = crc_data;
        watching = 1'b1;
      end else if (watching) begin
        if (out_valid || rst) watching = 1'b0;
        else if (crc_data !== snap) unstable++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic sof);
    in_valid = 1'b1;
    in_data  = b;
    in_sof   = sof;
    @(negedge clk);
  endtask

  task automatic check_stats();
`ifdef PKT_FRAMER_STATS_EN
    chk("stat_ok", W'(stat_ok), W'(e_ok));
    chk("stat_bad", W'(stat_bad), W'(e_bad));
    chk("stat_drop", W'(stat_drop), W'(e_drop));
`endif
  endtask

  task automatic check_out(input int hold);
    sb_t e;
    bit stable;
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk("out_valid_wait", W'(out_valid), W'(1));
    if (!out_valid) return;
    chk("out_payload", out_payload, e.payload);
    chk("out_crc_ok", W'(out_crc_ok), W'(e.ok));
    chk("out_timeout", W'(out_timeout), W'(e.to));
    chk("out_latency", W'(cyc - cv_cyc), W'(e.delta));
    chk("crc_data", cv_data, e.payload);
    chk("crc_pulses", W'(crc_pulses), W'(1));
    chk("crc_data_stable", W'(unstable), W'(0));
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!out_valid || out_payload !== e.payload || out_crc_ok !== e.ok ||
          out_timeout !== e.to || in_ready !== 1'b0) stable = 1'b0;
    end
    chk("hold_stable", W'(stable), W'(1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_valid", W'(out_valid), W'(0));
    chk("handoff_ready", W'(in_ready), W'(1));
    if (e.ok) e_ok++; else e_bad++;
    check_stats();
  endtask

  task automatic run_frame(input logic [W-1:0] p, input logic [31:0] f, input int delay,
                           input bit rc, input logic [31:0] scrc, input bit eok, input bit eto,
                           input int edelta, input int hold, input int pre_drop, input int pre_sof);
    logic [W-1:0] s;
    logic [31:0]  fs;
    stub_delay = delay;
    stub_real  = rc;
    stub_crc   = scrc;
    crc_pulses = 0;
    unstable   = 0;
    sb.push_back('{payload: p, ok: eok, to: eto, delta: edelta});
    for (int i = 0; i < pre_drop; i++) send_byte(8'(8'hC0 + i), 1'b0);
    e_drop += pre_drop;
    for (int i = 0; i < pre_sof; i++) send_byte(8'(8'h50 + i), i == 0);
    if (pre_sof > 0) e_drop++;
    s = p;
    for (int i = 0; i < PB; i++) begin
      send_byte(s[W-1:W-8], i == 0);
      s = s << 8;
    end
    fs = f;
    for (int j = 0; j < 4; j++) begin
      send_byte(fs[7:0], 1'b0);
      fs = fs >> 8;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check_out(hold);
  endtask

  initial begin
    logic [W-1:0] p;
    logic [31:0]  f;
    vt[0] = '{0, 32'hDEADBEEF, 0, 42, 0, 32'hDEADBEEF, 1, 0, 43};  // good frame
    vt[1] = '{0, 32'h00000000, 0, 42, 0, 32'hDEADBEEF, 0, 0, 43};  // bad FCS
    vt[2] = '{1, 32'h0,        1, 42, 1, 32'h0,        1, 0, 43};  // software CRC
    vt[3] = '{0, 32'hDEADBEEF, 0, -1, 0, 32'h0,        0, 1, 65};  // no answer
    vt[4] = '{0, 32'hDEADBEEF, 0, 64, 0, 32'hDEADBEEF, 1, 0, 65};  // done on expiry cycle
    vt[5] = '{0, 32'hDEADBEEF, 0, 65, 0, 32'hDEADBEEF, 0, 1, 65};  // late done ignored
    vt[6] = '{1, 32'h12345678, 0, 1,  0, 32'h12345678, 1, 0, 2};   // fastest engine

    repeat (3) @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_crc_valid", W'(crc_valid), W'(0));
    chk("rst_crc_data", crc_data, '0);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_payload", out_payload, '0);
    chk("rst_out_crc_ok", W'(out_crc_ok), W'(0));
    chk("rst_out_timeout", W'(out_timeout), W'(0));
    check_stats();
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      p = gen(vt[v].rnd);
      f = vt[v].fcs_sw ? crc32(p) : vt[v].fcs;
      run_frame(p, f, vt[v].delay, vt[v].real_crc, vt[v].scrc, vt[v].eok, vt[v].eto,
                vt[v].edelta, (v == 3) ? 5 : 1, 0, 0);
    end

    // SOF restart while collecting payload
    p = gen(1);
    p = {8'hAA, p[W-9:0]};
    run_frame(p, 32'hDEADBEEF, 42, 0, 32'hDEADBEEF, 1, 0, 43, 1, 0, 10);
    // stray bytes in IDLE, then SOF restart in the middle of the FCS
    p = gen(1);
    run_frame(p, crc32(p), 20, 1, 32'h0, 1, 0, 21, 2, 3, 42);

    // reset in the middle of a frame
    p = gen(1);
    for (int i = 0; i < 20; i++) send_byte(8'(8'h11 * i + 1), i == 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_crc_data", crc_data, '0);
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_out_payload", out_payload, '0);
    e_ok = 0; e_bad = 0; e_drop = 0;
    check_stats();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(p, 32'hCAFEF00D, 42, 0, 32'hCAFEF00D, 1, 0, 43, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "global timeout");
  end

endmodule
